// File: rtl/aes_dec_pkg.sv
// ---------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the AES decipher round engine: key-length codes,
// round counts, FSM state encodings and GF(2^8) helpers used by the
// InvMixColumns / InvShiftRows datapath.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_dec_pkg;

    typedef enum logic [1:0] {
        KEYLEN_128     = 2'b00,
        KEYLEN_192     = 2'b01,
        KEYLEN_256     = 2'b10,
        KEYLEN_256_ALT = 2'b11   // reserved code, behaves as AES-256
    } keylen_e;

    localparam logic [3:0] NR_AES128 = 4'd10;
    localparam logic [3:0] NR_AES192 = 4'd12;
    localparam logic [3:0] NR_AES256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INIT = 2'b01,
        ST_SBOX = 2'b10,
        ST_MAIN = 2'b11
    } state_e;

    function automatic logic [3:0] num_rounds(input logic [1:0] keylen);
        case (keylen)
            KEYLEN_128: return NR_AES128;
            KEYLEN_192: return NR_AES192;
            default:    return NR_AES256;
        endcase
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1 (0x11b).
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] b);
        return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
    endfunction

    // State bytes are column-major, byte 0 = bits 127:120. Row r is rotated
    // right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
// ---------------------------------------------------------------------------
// aes_inv_mixcolumns
// InvMixColumns over a full 128-bit state (combinational). Each 32-bit column
// is multiplied by the circulant {0e,0b,0d,09} in GF(2^8).
// Ports:
//   i_state  in  128  state, column 0 = bits 127:96
//   o_state  out 128  InvMixColumns(i_state)
// ---------------------------------------------------------------------------
module aes_inv_mixcolumns
    import aes_dec_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;

        assign w_a0 = i_state[127 - 32*c -: 8];
        assign w_a1 = i_state[119 - 32*c -: 8];
        assign w_a2 = i_state[111 - 32*c -: 8];
        assign w_a3 = i_state[103 - 32*c -: 8];

        assign o_state[127 - 32*c -: 8] = gm14(w_a0) ^ gm11(w_a1) ^ gm13(w_a2) ^ gm9(w_a3);
        assign o_state[119 - 32*c -: 8] = gm9(w_a0)  ^ gm14(w_a1) ^ gm11(w_a2) ^ gm13(w_a3);
        assign o_state[111 - 32*c -: 8] = gm13(w_a0) ^ gm9(w_a1)  ^ gm14(w_a2) ^ gm11(w_a3);
        assign o_state[103 - 32*c -: 8] = gm11(w_a0) ^ gm13(w_a1) ^ gm9(w_a2)  ^ gm14(w_a3);
    end

endmodule

// File: rtl/aes_inv_sbox.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox
// Inverse AES S-box applied to each byte of a 32-bit word (pure combinational).
// Ports:
//   i_word  in  32  word to substitute
//   o_word  out 32  byte-wise inverse-substituted word
// ---------------------------------------------------------------------------
module aes_inv_sbox (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_word = {INV_SBOX[i_word[31:24]], INV_SBOX[i_word[23:16]],
                     INV_SBOX[i_word[15:8]],  INV_SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_decipher_block_p.sv
// ---------------------------------------------------------------------------
// aes_decipher_block_p
// Iterative AES inverse-cipher round engine (AES-128/192/256). Each round is
// SBOX_LANES-wide InvSubBytes spread over 4/SBOX_LANES cycles, followed by one
// MAIN cycle of InvShiftRows, AddRoundKey and (except in the last round)
// InvMixColumns. Round keys come from an external key memory addressed by
// the round output.
//
// Build option: define AES_DEC_ABORT_EN to add the abort input, which drops
// a running operation and clears the state register.
//
// Ports:
//   clk        in   1    clock, rising edge
//   reset_n    in   1    asynchronous active-low reset
//   next       in   1    start request, honoured only in IDLE
//   keylen     in   2    00=AES-128, 01=AES-192, 1x=AES-256 (latched on start)
//   round      out  4    round counter; key memory returns key (Nr - round)
//   round_key  in   128  round key for the current round
//   block      in   128  ciphertext, sampled in INIT
//   new_block  out  128  state register; plaintext once ready is high
//   ready      out  1    idle / result valid
//   done       out  1    single-cycle completion pulse
//   abort      in   1    (AES_DEC_ABORT_EN only) cancel running operation
// ---------------------------------------------------------------------------
module aes_decipher_block_p
    import aes_dec_pkg::*;
#(
    parameter int SBOX_LANES = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [1:0]   keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready,
    output logic         done
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
        $error("aes_decipher_block_p: SBOX_LANES must be 1, 2 or 4");
    end

    localparam int         GROUPS     = 4 / SBOX_LANES;
    localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);

    state_e         r_state,  w_state_d;
    logic [127:0]   r_block,  w_block_d;
    logic [3:0]     r_round,  w_round_d;
    logic [1:0]     r_grp,    w_grp_d;
    logic [1:0]     r_keylen, w_keylen_d;
    logic           r_ready,  w_ready_d;
    logic           r_done,   w_done_d;

    logic [3:0]     w_nr;
    logic [31:0]    w_words     [4];
    logic [31:0]    w_words_sub [4];
    logic [127:0]   w_block_sub;
    logic [127:0]   w_shift_key;
    logic [127:0]   w_mixed;
    logic [1:0]     w_word_idx  [SBOX_LANES];
    logic [31:0]    w_sbox_in   [SBOX_LANES];
    logic [31:0]    w_sbox_out  [SBOX_LANES];

    assign w_nr = num_rounds(r_keylen);

    for (genvar i = 0; i < 4; i++) begin : g_word
        assign w_words[i] = r_block[127 - 32*i -: 32];
    end

    // Lane l of group g works on word g*L + l.
    for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
        assign w_word_idx[l] = 2'(int'(r_grp) * SBOX_LANES + l);
        assign w_sbox_in[l]  = w_words[w_word_idx[l]];

        aes_inv_sbox u_inv_sbox (
            .i_word (w_sbox_in[l]),
            .o_word (w_sbox_out[l])
        );
    end

    always_comb begin
        w_words_sub = w_words;
        for (int l = 0; l < SBOX_LANES; l++) begin
            w_words_sub[w_word_idx[l]] = w_sbox_out[l];
        end
    end

    assign w_block_sub = {w_words_sub[0], w_words_sub[1], w_words_sub[2], w_words_sub[3]};

    // InvSubBytes already happened in SBOX; bytes commute with InvShiftRows.
    assign w_shift_key = inv_shift_rows(r_block) ^ round_key;

    aes_inv_mixcolumns u_inv_mixcolumns (
        .i_state (w_shift_key),
        .o_state (w_mixed)
    );

    always_comb begin
        // NOTE: every next-state variable is given its hold value before the case, so no path can infer a latch.
        w_state_d  = r_state;
        w_block_d  = r_block;
        w_round_d  = r_round;
        w_grp_d    = r_grp;
        w_keylen_d = r_keylen;
        w_ready_d  = r_ready;
        w_done_d   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (next) begin
                    w_round_d  = '0;
                    w_ready_d  = 1'b0;
                    w_keylen_d = keylen;
                    w_state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                w_block_d = block ^ round_key;
                w_round_d = 4'd1;
                w_grp_d   = '0;
                w_state_d = ST_SBOX;
            end
            ST_SBOX: begin
                w_block_d = w_block_sub;
                if (r_grp == LAST_GROUP) begin
                    w_grp_d   = '0;
                    w_state_d = ST_MAIN;
                end else begin
                    w_grp_d = r_grp + 2'd1;
                end
            end
            ST_MAIN: begin
                w_round_d = r_round + 4'd1;
                if (r_round < w_nr) begin
                    w_block_d = w_mixed;
                    w_state_d = ST_SBOX;
                end else begin
                    w_block_d = w_shift_key;
                    w_ready_d = 1'b1;
                    w_done_d  = 1'b1;
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_grp_d   = '0;
                w_ready_d = 1'b1;
                w_state_d = ST_IDLE;
            end
        endcase

`ifdef AES_DEC_ABORT_EN
        // Abort wins over every transition and wipes the partial state.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_d = ST_IDLE;
            w_block_d = '0;
            w_round_d = '0;
            w_grp_d   = '0;
            w_ready_d = 1'b1;
            w_done_d  = 1'b0;
        end
`endif
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_block  <= '0;
            r_round  <= '0;
            r_grp    <= '0;
            r_keylen <= KEYLEN_128;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_block  <= w_block_d;
            r_round  <= w_round_d;
            r_grp    <= w_grp_d;
            r_keylen <= w_keylen_d;
            r_ready  <= w_ready_d;
            r_done   <= w_done_d;
        end
    end

    assign new_block = r_block;
    assign round     = r_round;
    assign ready     = r_ready;
    assign done      = r_done;

endmodule

// File: doc/aes_decipher_block_p.md
Name: aes_decipher_block_p

Overview:
Parametrised next-generation AES decipher round engine. Iterates the standard inverse cipher (InvSubBytes, InvShiftRows, AddRoundKey, InvMixColumns) over one 128-bit block. Adds AES-192 support, a configurable number of parallel inverse S-box lanes, keylen latching and a done pulse. Sits beside the encipher block under the AES core. It is fed round keys by the key memory, indexed by the round output.

Parameters:
SBOX_LANES, 1, number of 32-bit inverse S-box words substituted per cycle; legal values 1, 2, 4 (any other value is an elaboration error).

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
next  in  1  start request, sampled only in IDLE
keylen  in  2  00=AES-128 (10 rounds), 01=AES-192 (12), 10=AES-256 (14), 11 treated as AES-256
round  out  4  current round counter; key memory returns round_key for (Nr - round) combinationally
round_key  in  128  round key for current round, used the same cycle
block  in  128  ciphertext, sampled in INIT
new_block  out  128  state register; holds plaintext once ready is high
ready  out  1  high when idle/result valid
done  out  1  one-cycle pulse coincident with ready rising at completion

Behaviour:
- Reset values: new_block=0, round=0, ready=1, done=0, state=IDLE, sword group counter=0, latched keylen=00.
- G = 4/SBOX_LANES S-box cycles per round. Nr is taken from keylen latched in IDLE on next; mid-operation keylen changes are ignored.
- IDLE: on next, round_ctr<=0, ready<=0, latch keylen, go INIT. next is ignored in all other states.
- INIT (1 cycle): state<=block^round_key; round_ctr<=1; group ctr<=0; go SBOX.
- SBOX (G cycles): group g substitutes words g*L..g*L+L-1 (word0 = bits 127:96), with L = SBOX_LANES. Other words are held. Group ctr increments; after the last group, go MAIN.
- MAIN (1 cycle): if round_ctr<Nr, state<=InvMixColumns(InvShiftRows(state)^round_key); round_ctr++; go SBOX. Else state<=InvShiftRows(state)^round_key; round_ctr++; ready<=1; done<=1 for one cycle; go IDLE.
- InvMixColumns uses coefficients 0e,0b,0d,09 over GF(2^8), polynomial 0x11b.
- Latency: ready rises 1+Nr*(G+1) cycles after the edge that samples next. Examples: L=1/Nr=10 gives 51; L=4/Nr=14 gives 29.
- new_block is undefined-but-stable while busy and must only be consumed when ready=1. It holds the result until the next INIT.
- next high on the completion cycle has no effect; the following cycle (IDLE) accepts it.
- Asynchronous reset mid-operation returns everything to reset values immediately. No partial result is retained.
- Illegal state encodings return to IDLE with ready=1.

Optional Feature:
AES_DEC_ABORT_EN: adds input port abort (1 bit).
- With the macro: abort high in any non-IDLE state causes, on the next edge, state<=IDLE, ready<=1, done stays 0, new_block<=0 (no partial-plaintext leakage), round<=0. abort has priority over all transitions and is ignored in IDLE.
- Without the macro: the port does not exist and every started operation runs to completion.

Decomposition:
- Package aes_dec_pkg: keylen codes, round counts (10/12/14), FSM state encodings (IDLE, INIT, SBOX, MAIN), GF multiply functions gm2/gm9/gm11/gm13/gm14.
- Reuse existing aes_inv_sbox (32-bit word) instantiated SBOX_LANES times in a generate loop.
- One new combinational sub-module, aes_inv_mixcolumns (128-bit in/out), so the encipher side can share the structure.

Test Plan:
- AES-128, L=1, key 000102..0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, bench key model indexed by round -> new_block 00112233445566778899aabbccddeeff, ready high exactly 51 cycles after next, done pulses once.
- AES-192, L=2, key 000102..17, block dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 1+12*3=37 cycles.
- AES-256, L=4, key 000102..1f, block 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff after 29 cycles; keylen=11 gives an identical result.
- Toggle keylen and pulse next mid-operation -> result and latency unchanged; back-to-back next asserted on the completion cycle is ignored, then accepted one cycle later.
- Assert reset_n low at cycle 20 of a run -> immediately new_block=0, ready=1, round=0; a fresh run then completes correctly.
- With AES_DEC_ABORT_EN: abort at cycle 10 -> next edge ready=1, done=0, new_block=0, round=0; the next run is correct.
